// File: rtl/branch_update_queue.sv
// ---------------------------------------------------------------------------
// branch_update_queue
//
// Tracks in-flight branch predictions in a circular buffer and turns each
// in-order resolution into a registered predictor-update packet.
// A mispredicted resolution also discards every younger wrong-path entry,
// drives a repaired global history, and holds off new predictions for one
// recovery cycle.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   pred_valid/pred_*     : new prediction to enqueue (PC, GHR snapshot,
//                           gselect, local and final tournament predictions)
//   pred_ready            : an entry can be accepted this cycle
//   resolve_valid/_taken  : outcome of the oldest in-flight branch
//   upd_valid/upd_*       : one-cycle update packet for the retired branch
//   mispredict            : final prediction was wrong (pulses with upd_valid)
//   repair_ghr            : corrected global history, valid with mispredict
//   count                 : current occupancy
//   resolve_error         : sticky, resolution seen with nothing to retire
// ---------------------------------------------------------------------------
module branch_update_queue #(
  parameter int DEPTH     = 8,
  parameter int PC_WIDTH  = 32,
  parameter int GHR_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic [PC_WIDTH-1:0]    pred_pc,
  input  logic [GHR_WIDTH-1:0]   pred_ghr,
  input  logic                   pred_global,
  input  logic                   pred_local,
  input  logic                   pred_taken,
  output logic                   pred_ready,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  output logic                   upd_valid,
  output logic [PC_WIDTH-1:0]    upd_pc,
  output logic [GHR_WIDTH-1:0]   upd_ghr,
  output logic                   upd_taken,
  output logic                   upd_choice_en,
  output logic                   upd_choice_global,
  output logic                   mispredict,
  output logic [GHR_WIDTH-1:0]   repair_ghr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   resolve_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // Entry storage: data only, never reset (occupancy lives in count_q).
  logic [PC_WIDTH-1:0]  pc_mem  [DEPTH];
  logic [GHR_WIDTH-1:0] ghr_mem [DEPTH];
  logic                 glb_mem [DEPTH];
  logic                 loc_mem [DEPTH];
  logic                 tak_mem [DEPTH];

  // Control state
  state_t           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  // Held low through reset and the first edge after it so pred_ready
  // only rises once the block is out of reset.
  logic             alive_q;

  // Update packet registers
  logic                 upd_valid_q, upd_valid_d;
  logic                 mis_q, mis_d;
  logic [PC_WIDTH-1:0]  upd_pc_q, upd_pc_d;
  logic [GHR_WIDTH-1:0] upd_ghr_q, upd_ghr_d;
  logic                 upd_taken_q, upd_taken_d;
  logic                 cen_q, cen_d;
  logic                 cglb_q, cglb_d;

  logic full, empty, do_push, do_pop, do_mis;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign pred_ready = alive_q && (state_q == RUN) && !full;
  assign do_push    = pred_valid && pred_ready;
  // Resolutions are only honoured in RUN; in RECOVER they count as errors.
  assign do_pop     = resolve_valid && !empty && (state_q == RUN);
  assign do_mis     = do_pop && (tak_mem[head_q] != resolve_taken);

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    err_d       = err_q;
    upd_valid_d = do_pop;
    mis_d       = do_mis;
    upd_pc_d    = upd_pc_q;
    upd_ghr_d   = upd_ghr_q;
    upd_taken_d = upd_taken_q;
    cen_d       = cen_q;
    cglb_d      = cglb_q;

    if (resolve_valid && !do_pop) begin
      err_d = 1'b1;
    end

    if (do_pop) begin
      upd_pc_d    = pc_mem[head_q];
      upd_ghr_d   = ghr_mem[head_q];
      upd_taken_d = resolve_taken;
      cen_d       = (glb_mem[head_q] != loc_mem[head_q]);
      cglb_d      = (glb_mem[head_q] == resolve_taken);
    end

    if (do_mis) begin
      // Flush everything younger than the retiring entry; any push in this
      // cycle is wrong-path and is dropped as well.
      head_d  = head_q + PTR_W'(1);
      tail_d  = head_q + PTR_W'(1);
      count_d = '0;
      state_d = RECOVER;
    end else begin
      head_d  = head_q + PTR_W'(do_pop);
      tail_d  = tail_q + PTR_W'(do_push);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (state_q == RECOVER) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      alive_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      upd_pc_q    <= '0;
      upd_ghr_q   <= '0;
      upd_taken_q <= 1'b0;
      cen_q       <= 1'b0;
      cglb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      err_q       <= err_d;
      alive_q     <= 1'b1;
      upd_valid_q <= upd_valid_d;
      mis_q       <= mis_d;
      upd_pc_q    <= upd_pc_d;
      upd_ghr_q   <= upd_ghr_d;
      upd_taken_q <= upd_taken_d;
      cen_q       <= cen_d;
      cglb_q      <= cglb_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !do_mis) begin
      pc_mem[tail_q]  <= pred_pc;
      ghr_mem[tail_q] <= pred_ghr;
      glb_mem[tail_q] <= pred_global;
      loc_mem[tail_q] <= pred_local;
      tak_mem[tail_q] <= pred_taken;
    end
  end

  assign upd_valid         = upd_valid_q;
  assign upd_pc            = upd_pc_q;
  assign upd_ghr           = upd_ghr_q;
  assign upd_taken         = upd_taken_q;
  assign upd_choice_en     = cen_q;
  assign upd_choice_global = cglb_q;
  assign mispredict        = mis_q;
  assign repair_ghr        = {upd_ghr_q[GHR_WIDTH-2:0], upd_taken_q};
  assign count             = count_q;
  assign resolve_error     = err_q;

endmodule

// File: tb/tb_branch_update_queue.sv
module tb_branch_update_queue;

  localparam int DEPTH = 8;
  localparam int PCW   = 32;
  localparam int GW    = 12;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            pred_valid = 1'b0;
  logic [PCW-1:0]  pred_pc = '0;
  logic [GW-1:0]   pred_ghr = '0;
  logic            pred_global = 1'b0, pred_local = 1'b0, pred_taken = 1'b0;
  logic            pred_ready;
  logic            resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic            upd_valid;
  logic [PCW-1:0]  upd_pc;
  logic [GW-1:0]   upd_ghr;
  logic            upd_taken, upd_choice_en, upd_choice_global, mispredict;
  logic [GW-1:0]   repair_ghr;
  logic [$clog2(DEPTH):0] count;
  logic            resolve_error;

  branch_update_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .GHR_WIDTH(GW)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ghr(pred_ghr),
    .pred_global(pred_global), .pred_local(pred_local), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_choice_en(upd_choice_en), .upd_choice_global(upd_choice_global),
    .mispredict(mispredict), .repair_ghr(repair_ghr),
    .count(count), .resolve_error(resolve_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [GW-1:0]  ghr;
    bit g, l, t;
  } ent_t;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [GW-1:0]  ghr;
    bit taken, cen, cglb, mis;
    logic [GW-1:0]  repair;
  } pkt_t;

  // Reference model: in-flight branches as a plain queue, plus flags.
  ent_t q[$];
  pkt_t sb[$];
  bit   m_err   = 0;
  bit   m_rec   = 0;
  bit   m_alive = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented update packet against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (upd_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_update: got upd_pc %0h, expected no packet", upd_pc);
        end else begin
          pkt_t p;
          p = sb.pop_front();
          chk("upd_pc", upd_pc, p.pc);
          chk("upd_ghr", upd_ghr, p.ghr);
          chk("upd_taken", upd_taken, p.taken);
          chk("upd_choice_en", upd_choice_en, p.cen);
          chk("upd_choice_global", upd_choice_global, p.cglb);
          chk("mispredict", mispredict, p.mis);
          if (p.mis) chk("repair_ghr", repair_ghr, p.repair);
        end
      end else begin
        chk("mispredict_idle", mispredict, 0);
      end
    end
  end

  // One cycle of stimulus: drive at the falling edge, check the DUT's
  // visible state against the model, then advance the model.
  task automatic step(input bit pv, input logic [PCW-1:0] pc, input logic [GW-1:0] ghr,
                      input bit g, input bit l, input bit t, input bit rv, input bit rt);
    bit m_ready, push, rec_next;
    ent_t e;
    pkt_t p;
    @(negedge clock);
    pred_valid = pv; pred_pc = pc; pred_ghr = ghr;
    pred_global = g; pred_local = l; pred_taken = t;
    resolve_valid = rv; resolve_taken = rt;
    m_ready = m_alive && !m_rec && (q.size() < DEPTH);
    chk("pred_ready", pred_ready, m_ready);
    chk("count", count, q.size());
    chk("resolve_error", resolve_error, m_err);
    push = pv && m_ready;
    rec_next = 0;
    if (rv) begin
      if (q.size() == 0 || m_rec) begin
        m_err = 1;
      end else begin
        e = q.pop_front();
        p.pc = e.pc; p.ghr = e.ghr; p.taken = rt;
        p.cen = (e.g != e.l);
        p.cglb = (e.g == rt);
        p.mis = (e.t != rt);
        p.repair = {e.ghr[GW-2:0], rt};
        sb.push_back(p);
        if (p.mis) begin
          q.delete();
          push = 0;
          rec_next = 1;
        end
      end
    end
    if (push) begin
      e.pc = pc; e.ghr = ghr; e.g = g; e.l = l; e.t = t;
      q.push_back(e);
    end
    m_rec = rec_next;
  endtask

  task automatic idle();
    step(0, '0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic zero_inputs();
    pred_valid = 0; pred_pc = '0; pred_ghr = '0;
    pred_global = 0; pred_local = 0; pred_taken = 0;
    resolve_valid = 0; resolve_taken = 0;
  endtask

  // Asserts reset immediately (whatever the clock phase), checks that every
  // output is cleared, and returns once the block is accepting again.
  task automatic do_reset();
    reset = 1;
    zero_inputs();
    #1;
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_count", count, 0);
    chk("rst_resolve_error", resolve_error, 0);
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_upd_ghr", upd_ghr, 0);
    chk("rst_upd_fields", {upd_taken, upd_choice_en, upd_choice_global}, 0);
    chk("rst_repair_ghr", repair_ghr, 0);
    q.delete(); sb.delete();
    m_err = 0; m_rec = 0; m_alive = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_pred_ready", pred_ready, 0);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    m_alive = 1;
  endtask

  function automatic bit front_taken();
    if (q.size() == 0) return 1'($urandom_range(0, 1));
    return q[0].t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Three pushes, no resolves.
    for (int i = 0; i < 3; i++)
      step(1, 32'h100 + 4 * i, 12'($urandom), 1'($urandom), 1'($urandom), 1, 0, 0);
    idle();
    chk("three_push_count", count, 3);
    chk("three_push_ready", pred_ready, 1);

    // Oldest resolves taken, matching prediction.
    step(0, '0, '0, 0, 0, 0, 1, 1);
    idle();
    chk("after_pop_count", count, 2);
    repeat (2) step(0, '0, '0, 0, 0, 0, 1, front_taken());
    idle();

    // Fill to DEPTH, attempt an extra push, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1, 32'h300 + 4 * i, 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    step(1, 32'h200, 12'h0, 0, 0, 0, 0, 0);
    chk("full_ready_low", pred_ready, 0);
    for (int i = 0; i < DEPTH; i++)
      step(0, '0, '0, 0, 0, 0, 1, front_taken());
    idle();

    // Mispredict with two younger entries; push in the same cycle is dropped.
    step(1, 32'h400, 12'hABC, 1, 0, 0, 0, 0);
    step(1, 32'h404, 12'h111, 0, 0, 1, 0, 0);
    step(1, 32'h408, 12'h222, 1, 1, 1, 0, 0);
    step(1, 32'h40C, 12'h333, 0, 1, 0, 1, 1);
    idle();
    chk("recover_count", count, 0);
    chk("recover_ready", pred_ready, 0);
    idle();
    chk("post_recover_ready", pred_ready, 1);

    // Resolve on an empty queue: sticky error, no update.
    step(0, '0, '0, 0, 0, 0, 1, 1);
    repeat (3) idle();
    chk("sticky_error", resolve_error, 1);

    // Random traffic with matching outcomes; asynchronous reset mid-run.
    for (int i = 0; i < 100; i++) begin
      bit rv;
      rv = ($urandom_range(0, 9) < 4);
      step(($urandom_range(0, 9) < 6), $urandom, 12'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), rv, front_taken());
      if (i == 60) begin
        @(posedge clock);
        #3;
        do_reset();
      end
    end

    // Random traffic with occasional mispredictions and recoveries.
    for (int i = 0; i < 150; i++) begin
      bit rv;
      rv = ($urandom_range(0, 9) < 4);
      step(($urandom_range(0, 9) < 6), $urandom, 12'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), rv, front_taken() ^ ($urandom_range(0, 6) == 0));
    end

    repeat (3) idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
